otter_decode_stage: RTL

- Registered instruction-decode stage for the pipelined OTTER RV32I core; sits between fetch and execute.
- Decodes every RV32I base opcode plus the Zicsr and mret subset into a registered control bundle: ALU function and operand selects, write-back select, branch/jump class, generated immediate, and an illegal-instruction flag.
- valid/ready on both sides; flush input; latched interrupt-request injection.
- Branch resolution moves to execute; this stage emits the branch class only.

---
 rtl/otter_pkg.sv | 100 ++++++++++
 rtl/otter_decode_stage_if.sv | 44 ++++
 rtl/otter_imm_gen.sv | 31 +++
 rtl/otter_decode_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared definitions for the OTTER decode stage: opcode constants, control
// field encodings, immediate format select and the registered control bundle.
package otter_pkg;

  localparam int unsigned XLEN_W = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSN_MRET = 32'h30200073;

  // Low three bits follow funct3; bit 3 marks sub/sra (and the lui copy).
  typedef enum logic [3:0] {
    ALU_ADD      = 4'b0000,
    ALU_SLL      = 4'b0001,
    ALU_SLT      = 4'b0010,
    ALU_SLTU     = 4'b0011,
    ALU_XOR      = 4'b0100,
    ALU_SRL      = 4'b0101,
    ALU_OR       = 4'b0110,
    ALU_AND      = 4'b0111,
    ALU_SUB      = 4'b1000,
    ALU_LUI_COPY = 4'b1001,
    ALU_SRA      = 4'b1101
  } alu_fun_t;

  typedef enum logic [1:0] {
    SRCA_RS1     = 2'd0,
    SRCA_U_IMM   = 2'd1,
    SRCA_NOT_RS1 = 2'd2
  } srcA_t;

  typedef enum logic [2:0] {
    SRCB_RS2   = 3'd0,
    SRCB_I_IMM = 3'd1,
    SRCB_S_IMM = 3'd2,
    SRCB_PC    = 3'd3,
    SRCB_CSR   = 3'd4
  } srcB_t;

  typedef enum logic [1:0] {
    WR_PC4  = 2'd0,
    WR_CSR  = 2'd1,
    WR_DMEM = 2'd2,
    WR_ALU  = 2'd3
  } wr_sel_t;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6
  } br_type_t;

  typedef enum logic [1:0] {
    JMP_NONE = 2'd0,
    JMP_JAL  = 2'd1,
    JMP_JALR = 2'd2,
    JMP_MRET = 2'd3
  } jump_t;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_t;

  typedef struct packed {
    logic [XLEN_W-1:0] pc;
    logic [XLEN_W-1:0] imm;
    alu_fun_t          alu_fun;
    srcA_t             alu_srcA;
    srcB_t             alu_srcB;
    wr_sel_t           rf_wr_sel;
    logic              rf_we;
    br_type_t          br_type;
    jump_t             jump;
    logic              mem_we;
    logic              mem_re;
    logic [2:0]        mem_size;
    logic              csr_we;
    logic              illegal;
    logic              trap;
  } decode_bundle_t;

endpackage

// File: rtl/otter_decode_stage_if.sv
// Fetch-side and execute-side signals of the decode stage.
//   master : environment (fetch drives in_*, flush, int_req; execute drives out_ready)
//   slave  : the decode stage itself
interface otter_decode_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_ir;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            int_req;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [3:0]      out_alu_fun;
  logic [1:0]      out_alu_srcA;
  logic [2:0]      out_alu_srcB;
  logic [1:0]      out_rf_wr_sel;
  logic            out_rf_we;
  logic [2:0]      out_br_type;
  logic [1:0]      out_jump;
  logic            out_mem_we;
  logic            out_mem_re;
  logic [2:0]      out_mem_size;
  logic            out_csr_we;
  logic            out_illegal;
  logic            out_trap;

  modport master (
    output in_valid, in_ir, in_pc, flush, int_req, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_alu_fun, out_alu_srcA,
           out_alu_srcB, out_rf_wr_sel, out_rf_we, out_br_type, out_jump,
           out_mem_we, out_mem_re, out_mem_size, out_csr_we, out_illegal, out_trap
  );

  modport slave (
    input  in_valid, in_ir, in_pc, flush, int_req, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_alu_fun, out_alu_srcA,
           out_alu_srcB, out_rf_wr_sel, out_rf_we, out_br_type, out_jump,
           out_mem_we, out_mem_re, out_mem_size, out_csr_we, out_illegal, out_trap
  );
endinterface

// File: rtl/otter_imm_gen.sv
// Immediate generator: builds the I/S/B/U/J immediates from the instruction
// word and returns the one selected by fmt (zero for IMM_NONE).
//   ir  : instruction bits [31:7] (opcode bits carry no immediate)
//   fmt : immediate format select
//   imm : sign-extended immediate
module otter_imm_gen
  import otter_pkg::*;
(
  input  logic [31:7] ir,
  input  imm_fmt_t    fmt,
  output logic [31:0] imm
);
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;

  assign i_imm = {{20{ir[31]}}, ir[31:20]};
  assign s_imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign b_imm = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
  assign u_imm = {ir[31:12], 12'b0};
  assign j_imm = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};

  always_comb begin
    case (fmt)
      IMM_I:   imm = i_imm;
      IMM_S:   imm = s_imm;
      IMM_B:   imm = b_imm;
      IMM_U:   imm = u_imm;
      IMM_J:   imm = j_imm;
      default: imm = '0;
    endcase
  end
endmodule

// File: rtl/otter_decode_stage.sv
// Registered RV32I (+Zicsr/mret) decode stage between fetch and execute.
//   CLK, RST : clock (rising edge), asynchronous active-high reset
//   bus      : slave side of otter_decode_stage_if -- in_valid/in_ready/in_ir/
//              in_pc from fetch, flush, int_req, and the registered control
//              bundle with out_valid/out_ready toward execute
module otter_decode_stage
  import otter_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter bit          ENABLE_CSR   = 1'b1,
  parameter bit          RST_PC_VALID = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RST,
  otter_decode_stage_if.slave  bus
);

  if (XLEN != XLEN_W) begin : g_xlen_check
    $error("otter_decode_stage: only XLEN=32 is supported");
  end

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  assign opcode = bus.in_ir[6:0];
  assign rd     = bus.in_ir[11:7];
  assign funct3 = bus.in_ir[14:12];
  assign funct7 = bus.in_ir[31:25];

  imm_fmt_t    fmt;
  logic [31:0] gen_imm;

  always_comb begin
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: fmt = IMM_I;
      OPC_STORE:                                  fmt = IMM_S;
      OPC_BRANCH:                                 fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:                         fmt = IMM_U;
      OPC_JAL:                                    fmt = IMM_J;
      default:                                    fmt = IMM_NONE;
    endcase
  end

  otter_imm_gen u_imm_gen (
    .ir  (bus.in_ir[31:7]),
    .fmt (fmt),
    .imm (gen_imm)
  );

  decode_bundle_t dec, trap_b, bundle_q;
  logic           illegal, wr_req;

  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    wr_req  = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.rf_wr_sel = WR_ALU;
        wr_req        = 1'b1;
        if (funct7 == 7'b0000000)
          dec.alu_fun = alu_fun_t'({1'b0, funct3});
        else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
          dec.alu_fun = alu_fun_t'({1'b1, funct3});
        else
          illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.alu_srcB  = SRCB_I_IMM;
        dec.rf_wr_sel = WR_ALU;
        wr_req        = 1'b1;
        case (funct3)
          3'b001: if (funct7 == 7'b0000000) dec.alu_fun = ALU_SLL;
                  else illegal = 1'b1;
          3'b101: if (funct7 == 7'b0000000) dec.alu_fun = ALU_SRL;
                  else if (funct7 == 7'b0100000) dec.alu_fun = ALU_SRA;
                  else illegal = 1'b1;
          default: dec.alu_fun = alu_fun_t'({1'b0, funct3});
        endcase
      end
      OPC_LUI: begin
        dec.alu_fun   = ALU_LUI_COPY;
        dec.alu_srcA  = SRCA_U_IMM;
        dec.rf_wr_sel = WR_ALU;
        wr_req        = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_srcA  = SRCA_U_IMM;
        dec.alu_srcB  = SRCB_PC;
        dec.rf_wr_sel = WR_ALU;
        wr_req        = 1'b1;
      end
      OPC_LOAD: begin
        dec.alu_srcB  = SRCB_I_IMM;
        dec.rf_wr_sel = WR_DMEM;
        dec.mem_re    = 1'b1;
        dec.mem_size  = funct3;
        wr_req        = 1'b1;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) illegal = 1'b1;
      end
      OPC_STORE: begin
        dec.alu_srcB = SRCB_S_IMM;
        dec.mem_we   = 1'b1;
        dec.mem_size = funct3;
        if (funct3 > 3'b010) illegal = 1'b1;
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000:  dec.br_type = BR_BEQ;
          3'b001:  dec.br_type = BR_BNE;
          3'b100:  dec.br_type = BR_BLT;
          3'b101:  dec.br_type = BR_BGE;
          3'b110:  dec.br_type = BR_BLTU;
          3'b111:  dec.br_type = BR_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec.jump = JMP_JAL;
        wr_req   = 1'b1;
      end
      OPC_JALR: begin
        dec.jump = JMP_JALR;
        wr_req   = 1'b1;
        if (funct3 != 3'b000) illegal = 1'b1;
      end
      OPC_SYSTEM: begin
        if (!ENABLE_CSR) illegal = 1'b1;
        else begin
          case (funct3)
            // csrrw copies rs1; csrrs/csrrc combine with the csr value as
            // rs1|csr and ~rs1&csr respectively.
            3'b001: begin
              dec.csr_we    = 1'b1;
              dec.rf_wr_sel = WR_CSR;
              dec.alu_fun   = ALU_LUI_COPY;
              wr_req        = 1'b1;
            end
            3'b010: begin
              dec.csr_we    = 1'b1;
              dec.rf_wr_sel = WR_CSR;
              dec.alu_fun   = ALU_OR;
              dec.alu_srcB  = SRCB_CSR;
              wr_req        = 1'b1;
            end
            3'b011: begin
              dec.csr_we    = 1'b1;
              dec.rf_wr_sel = WR_CSR;
              dec.alu_fun   = ALU_AND;
              dec.alu_srcA  = SRCA_NOT_RS1;
              dec.alu_srcB  = SRCB_CSR;
              wr_req        = 1'b1;
            end
            3'b000: begin
              if (bus.in_ir == INSN_MRET) dec.jump = JMP_MRET;
              else illegal = 1'b1;
            end
            default: illegal = 1'b1;
          endcase
        end
      end
      default: illegal = 1'b1;
    endcase

    dec.imm = gen_imm;
    if (illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end else begin
      dec.rf_we = wr_req && (rd != 5'd0);
    end
    dec.pc = bus.in_pc;
  end

  always_comb begin
    trap_b      = '0;
    trap_b.trap = 1'b1;
    trap_b.pc   = bus.in_pc;
  end

  logic valid_q, int_pending, accept;

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q     <= RST_PC_VALID;
      int_pending <= 1'b0;
      bundle_q    <= '0;
    end else begin
      // A new request on the consuming edge keeps the flag set.
      int_pending <= bus.int_req || (int_pending && !accept);
      if (bus.flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q  <= 1'b1;
        bundle_q <= int_pending ? trap_b : dec;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid     = valid_q;
  assign bus.out_pc        = bundle_q.pc;
  assign bus.out_imm       = bundle_q.imm;
  assign bus.out_alu_fun   = bundle_q.alu_fun;
  assign bus.out_alu_srcA  = bundle_q.alu_srcA;
  assign bus.out_alu_srcB  = bundle_q.alu_srcB;
  assign bus.out_rf_wr_sel = bundle_q.rf_wr_sel;
  assign bus.out_rf_we     = bundle_q.rf_we;
  assign bus.out_br_type   = bundle_q.br_type;
  assign bus.out_jump      = bundle_q.jump;
  assign bus.out_mem_we    = bundle_q.mem_we;
  assign bus.out_mem_re    = bundle_q.mem_re;
  assign bus.out_mem_size  = bundle_q.mem_size;
  assign bus.out_csr_we    = bundle_q.csr_we;
  assign bus.out_illegal   = bundle_q.illegal;
  assign bus.out_trap      = bundle_q.trap;

endmodule
